// File: rtl/reindeer_machine_timer.sv
// Memory-mapped machine timer: a 64-bit mtime advanced by a programmable prescaler,
// a 64-bit mtimecmp compare, and a small register file with a carry-safe split read.
module reindeer_machine_timer #(
  parameter int PRESCALE_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sync_reset,
  input  logic        reg_read_enable,
  input  logic        reg_write_enable,
  input  logic [2:0]  reg_addr,
  input  logic [31:0] reg_write_data,
  output logic        reg_read_en_out,
  output logic [31:0] reg_read_data_out,
  output logic        addr_error,
  output logic        timer_triggered
);

  localparam logic [2:0] ADDR_MTIME_LO = 3'd0;
  localparam logic [2:0] ADDR_MTIME_HI = 3'd1;
  localparam logic [2:0] ADDR_CMP_LO   = 3'd2;
  localparam logic [2:0] ADDR_CMP_HI   = 3'd3;
  localparam logic [2:0] ADDR_CTRL     = 3'd4;
  localparam int         DIV_LSB       = 8;

  logic [63:0]              mtime;
  logic [63:0]              mtimecmp;
  logic [31:0]              shadow;
  logic                     enable;
  logic [PRESCALE_BITS-1:0] div;
  logic [PRESCALE_BITS-1:0] prescaler;
  logic                     tick;
  logic                     addr_invalid;
  logic [31:0]              ctrl_value;
  logic [31:0]              read_value;

  assign tick         = enable && (prescaler == div);
  assign addr_invalid = (reg_addr > ADDR_CTRL);

  always_comb begin
    ctrl_value = '0;
    ctrl_value[0] = enable;
    ctrl_value[DIV_LSB +: PRESCALE_BITS] = div;
  end

  // Read mux sees pre-write register values, so a simultaneous write returns old data.
  always_comb begin
    read_value = '0;
    case (reg_addr)
      ADDR_MTIME_LO: read_value = mtime[31:0];
      ADDR_MTIME_HI: read_value = shadow;
      ADDR_CMP_LO:   read_value = mtimecmp[31:0];
      ADDR_CMP_HI:   read_value = mtimecmp[63:32];
      ADDR_CTRL:     read_value = ctrl_value;
      default:       read_value = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mtime             <= '0;
      mtimecmp          <= '1;
      shadow            <= '0;
      enable            <= 1'b0;
      div               <= '0;
      prescaler         <= '0;
      reg_read_en_out   <= 1'b0;
      reg_read_data_out <= '0;
      addr_error        <= 1'b0;
      timer_triggered   <= 1'b0;
    end else if (sync_reset) begin
      mtime             <= '0;
      mtimecmp          <= '1;
      shadow            <= '0;
      enable            <= 1'b0;
      div               <= '0;
      prescaler         <= '0;
      reg_read_en_out   <= 1'b0;
      reg_read_data_out <= '0;
      addr_error        <= 1'b0;
      timer_triggered   <= 1'b0;
    end else begin
      if (reg_write_enable && reg_addr == ADDR_CTRL) begin
        prescaler <= '0;
        enable    <= reg_write_data[0];
        div       <= reg_write_data[DIV_LSB +: PRESCALE_BITS];
      end else if (!enable || tick) begin
        prescaler <= '0;
      end else begin
        prescaler <= prescaler + 1'b1;
      end

      // A software write to either mtime half wins over the tick in the same cycle.
      if (reg_write_enable && reg_addr == ADDR_MTIME_LO) begin
        mtime[31:0] <= reg_write_data;
      end else if (reg_write_enable && reg_addr == ADDR_MTIME_HI) begin
        mtime[63:32] <= reg_write_data;
      end else if (tick) begin
        mtime <= mtime + 64'd1;
      end

      if (reg_write_enable && reg_addr == ADDR_CMP_LO) mtimecmp[31:0]  <= reg_write_data;
      if (reg_write_enable && reg_addr == ADDR_CMP_HI) mtimecmp[63:32] <= reg_write_data;

      reg_read_en_out <= reg_read_enable;
      if (reg_read_enable) begin
        reg_read_data_out <= read_value;
        if (reg_addr == ADDR_MTIME_LO) shadow <= mtime[63:32];
      end

      addr_error      <= (reg_read_enable || reg_write_enable) && addr_invalid;
      timer_triggered <= (mtime >= mtimecmp);
    end
  end

endmodule

// File: tb/tb_reindeer_machine_timer.sv
// Directed bench for reindeer_machine_timer: prescaler rate, split reads, compare,
// write priority, invalid addresses and reset behaviour against hand-computed values.
module tb_reindeer_machine_timer;

  logic        clk;
  logic        reset;
  logic        sync_reset;
  logic        reg_read_enable;
  logic        reg_write_enable;
  logic [2:0]  reg_addr;
  logic [31:0] reg_write_data;
  logic        reg_read_en_out;
  logic [31:0] reg_read_data_out;
  logic        addr_error;
  logic        timer_triggered;

  int errors = 0;
  int checks = 0;

  reindeer_machine_timer #(.PRESCALE_BITS(8)) dut (
    .clk               (clk),
    .reset             (reset),
    .sync_reset        (sync_reset),
    .reg_read_enable   (reg_read_enable),
    .reg_write_enable  (reg_write_enable),
    .reg_addr          (reg_addr),
    .reg_write_data    (reg_write_data),
    .reg_read_en_out   (reg_read_en_out),
    .reg_read_data_out (reg_read_data_out),
    .addr_error        (addr_error),
    .timer_triggered   (timer_triggered)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_addr = a; reg_write_data = d; reg_write_enable = 1'b1;
    @(posedge clk); #1;
    reg_write_enable = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    reg_addr = a; reg_read_enable = 1'b1;
    @(posedge clk); #1;
    reg_read_enable = 1'b0;
    chk({tag, "_vld"}, 64'(reg_read_en_out), 64'd1);
    chk(tag, 64'(reg_read_data_out), 64'(exp));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Stop the timer and load a known mtime.
  task automatic load_mtime(input logic [31:0] hi, input logic [31:0] lo);
    wr(3'd4, 32'h0);
    wr(3'd0, lo);
    wr(3'd1, hi);
  endtask

  initial begin
    reset = 1'b1; sync_reset = 1'b0;
    reg_read_enable = 1'b0; reg_write_enable = 1'b0;
    reg_addr = '0; reg_write_data = '0;
    #12;
    chk("rst_vld",  64'(reg_read_en_out),   64'd0);
    chk("rst_data", 64'(reg_read_data_out), 64'd0);
    chk("rst_aerr", 64'(addr_error),        64'd0);
    chk("rst_trig", 64'(timer_triggered),   64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("rel_trig", 64'(timer_triggered), 64'd0);
    rd(3'd2, 32'hFFFF_FFFF, "rst_cmp_lo");
    rd(3'd3, 32'hFFFF_FFFF, "rst_cmp_hi");
    rd(3'd4, 32'h0, "rst_ctrl");

    // ctrl field masking: only enable and div survive
    wr(3'd4, 32'hFFFF_FFFF);
    rd(3'd4, 32'h0000_FF01, "ctrl_mask");

    // div=3: one tick every 4 cycles -> 10 in 40 cycles
    load_mtime(32'h0, 32'h0);
    wr(3'd4, 32'h0000_0301);
    idle(40);
    rd(3'd0, 32'd10, "presc_div3");

    // div=0: tick every cycle -> 40 in 40 cycles
    load_mtime(32'h0, 32'h0);
    wr(3'd4, 32'h0000_0001);
    idle(40);
    rd(3'd0, 32'd40, "presc_div0");

    // disabled: no advance
    load_mtime(32'h0, 32'h7);
    idle(10);
    rd(3'd0, 32'h7, "presc_off");

    // lo read at 0xFFFFFFFF, live hi already 1 when hi is read: shadow must give 0
    load_mtime(32'h0, 32'hFFFF_FFFE);
    wr(3'd4, 32'h0000_0001);
    idle(1);
    rd(3'd0, 32'hFFFF_FFFF, "carry_lo_ff");
    rd(3'd1, 32'h0, "carry_hi_0");
    // lo read at 0 after the carry: shadow must give 1
    load_mtime(32'h0, 32'hFFFF_FFFE);
    wr(3'd4, 32'h0000_0001);
    idle(2);
    rd(3'd0, 32'h0, "carry_lo_0");
    rd(3'd1, 32'h1, "carry_hi_1");

    // compare: mtime reaches 100 after 5 ticks, trigger one cycle later
    load_mtime(32'h0, 32'd95);
    wr(3'd2, 32'd100);
    wr(3'd3, 32'h0);
    wr(3'd4, 32'h0000_0001);
    for (int k = 1; k <= 5; k++) begin
      idle(1);
      chk($sformatf("cmp_pre%0d", k), 64'(timer_triggered), 64'd0);
    end
    idle(1);
    chk("cmp_rise", 64'(timer_triggered), 64'd1);
    wr(3'd3, 32'h1);
    chk("cmp_hold", 64'(timer_triggered), 64'd1);
    idle(1);
    chk("cmp_fall", 64'(timer_triggered), 64'd0);

    // write beats tick, counting resumes from the written value
    wr(3'd0, 32'h10);
    rd(3'd0, 32'h10, "prio_lo");
    rd(3'd0, 32'h11, "prio_next");
    rd(3'd1, 32'h0, "prio_hi");

    // invalid addresses
    load_mtime(32'h0, 32'h55);
    rd(3'd6, 32'h0, "inv_rd");
    chk("inv_rd_aerr", 64'(addr_error), 64'd1);
    idle(1);
    chk("inv_rd_aerr_end", 64'(addr_error), 64'd0);
    wr(3'd7, 32'hFFFF_FFFF);
    chk("inv_wr_aerr", 64'(addr_error), 64'd1);
    idle(1);
    chk("inv_wr_aerr_end", 64'(addr_error), 64'd0);
    rd(3'd0, 32'h55, "inv_mtime_lo");
    rd(3'd3, 32'h1, "inv_cmp_hi");
    rd(3'd4, 32'h0, "inv_ctrl");
    rd(3'd2, 32'd100, "inv_cmp_lo");
    idle(1);
    chk("hold_vld",  64'(reg_read_en_out),   64'd0);
    chk("hold_data", 64'(reg_read_data_out), 64'd100);

    // simultaneous read and write returns the pre-write value
    reg_addr = 3'd2; reg_write_data = 32'd200;
    reg_read_enable = 1'b1; reg_write_enable = 1'b1;
    @(posedge clk); #1;
    reg_read_enable = 1'b0; reg_write_enable = 1'b0;
    chk("rw_old", 64'(reg_read_data_out), 64'd100);
    rd(3'd2, 32'd200, "rw_new");

    // synchronous reset restores reset values
    load_mtime(32'h0, 32'h5);
    sync_reset = 1'b1;
    @(posedge clk); #1;
    sync_reset = 1'b0;
    rd(3'd0, 32'h0, "srst_mtime");
    rd(3'd2, 32'hFFFF_FFFF, "srst_cmp");

    // async reset with a read in flight
    load_mtime(32'h0, 32'h1234);
    reg_addr = 3'd0; reg_read_enable = 1'b1;
    @(posedge clk); #1;
    reg_read_enable = 1'b0;
    chk("mid_vld_before", 64'(reg_read_en_out), 64'd1);
    reset = 1'b1;
    #1;
    chk("mid_vld",  64'(reg_read_en_out),   64'd0);
    chk("mid_data", 64'(reg_read_data_out), 64'd0);
    chk("mid_trig", 64'(timer_triggered),   64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_rel_vld",  64'(reg_read_en_out), 64'd0);
    chk("mid_rel_trig", 64'(timer_triggered), 64'd0);
    rd(3'd3, 32'hFFFF_FFFF, "mid_cmp_hi");
    rd(3'd0, 32'h0, "mid_mtime");
    idle(3);
    chk("mid_trig_late", 64'(timer_triggered), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
